sync_sequencer: RTL and testbench
=================================

Name: sync_sequencer

Overview:
- Parametrised successor of the single-detector synchronisation FSM. Sequences one shot: start pulse, arm on the next fast-gate edge, wait for gate opening, fire detonator, confirm the wire sensor, then trigger up to N_DET detectors.
- Each detector has an enable bit and a ready handshake.
- Sits between the operator start input, the fast-gate timing source, the detonator driver and the detector trigger lines.

Parameters:
- N_DET, 4, number of detector trigger channels (1..16).
- CNT_W, 24, width of all cycle counters.
- FG_DELAY, 400000, cycles from fg_signal rising edge to detonator fire (2 ms at 200 MHz).
- PULSE_CYC, 200, width of detonator and detector trigger pulses in cycles.
- WIRE_TIMEOUT, 20000, cycles allowed from fire to wire confirmation.
- DEBOUNCE_CYC, 16, cycles wire_sensor must be stable high (WIRE_DEBOUNCE_EN only).

Ports:
- clock, input, 1, system clock.
- reset, input, 1, synchronous active-low reset.
- start_signal, input, 1, async start request; rising edge starts a shot.
- fg_signal, input, 1, async fast-gate timing pulse.
- wire_sensor, input, 1, async, bouncy breakwire/contact sensor.
- det_enable, input, N_DET, per-channel enable; sampled in ARMED on the fg edge.
- detector_ready, input, N_DET, per-channel ready (high = can accept a trigger).
- detonator_trigger, output, 1, detonator fire pulse.
- detector_trigger, output, N_DET, detector trigger pulses.
- busy, output, 1, high in any state other than IDLE.
- fault, output, 1, sticky fault flag; cleared by reset or by the next accepted start.
- fault_code, output, 2, 0 none, 1 wire timeout, 2 no enabled detector ready.

Behaviour:
- Inputs and synchronisation:
  - start_signal, fg_signal and wire_sensor each pass through a 2-flop synchroniser. Edges are detected on the synchronised value.
  - Input-to-decision latency is 3 cycles.
- Reset (reset==0 at a clock edge):
  - State goes to IDLE; all counters are cleared.
  - All outputs are 0: detonator_trigger=0, detector_trigger=0, busy=0, fault=0, fault_code=0.
  - Reset mid-shot aborts the shot immediately, including truncating any active pulse.
- IDLE:
  - On a start rising edge: clear fault and fault_code, go to ARMED.
- ARMED:
  - On an fg rising edge: latch mask = det_enable, load counter, go to WAIT_FG.
  - Further start edges are ignored.
- WAIT_FG:
  - Count FG_DELAY cycles; fg edges are ignored.
  - Then go to FIRE.
- FIRE:
  - detonator_trigger is high for exactly PULSE_CYC cycles.
  - The wire timeout counter starts on the first FIRE cycle.
  - After the pulse, go to WAIT_WIRE.
- WAIT_WIRE:
  - On wire confirmation: latch act = mask & detector_ready.
    - If act != 0, go to TRIG.
    - If act == 0, set fault, fault_code=2, go to IDLE.
  - Wire confirmation = first synchronised rising edge, or the debounced condition when WIRE_DEBOUNCE_EN is defined.
  - If WIRE_TIMEOUT cycles elapse since FIRE entry with no confirmation: set fault, fault_code=1, go to IDLE. No detector is triggered.
  - If confirmation and timeout occur in the same cycle, confirmation wins.
- TRIG:
  - detector_trigger = act for exactly PULSE_CYC cycles, all channels simultaneously.
  - Then go to WAIT_RDY.
- WAIT_RDY:
  - Wait until (detector_ready & act) == act, then go to IDLE.
  - There is no timeout in this state; only reset exits it.
- Counters:
  - Counters are CNT_W wide and saturate; they never wrap.
  - Parameters must fit in CNT_W (elaboration check).
- Simultaneous edges:
  - A start edge and an fg edge in the same cycle while in IDLE: only the start is taken; the shot arms on the next fg edge.

Optional Feature:
- Macro: WIRE_DEBOUNCE_EN.
- Defined: wire confirmation requires the synchronised wire_sensor to stay high for DEBOUNCE_CYC consecutive cycles. Any low sample restarts the count.
- Not defined: the first synchronised rising edge confirms, and DEBOUNCE_CYC is unused.

Test Plan:
Test parameters: FG_DELAY=100, PULSE_CYC=4, WIRE_TIMEOUT=500, N_DET=4, DEBOUNCE_CYC=8.
- Nominal shot:
  - Stimulus: start pulse; fg edge at cycle T with det_enable=4'b1011 and all ready; wire high 50 cycles after fire.
  - Required: detonator_trigger high for 4 cycles starting T+3+100 (±1 for the state transition); detector_trigger=4'b1011 for 4 cycles; busy=0 once ready returns.
- Wire timeout:
  - Stimulus: as nominal, wire_sensor held 0.
  - Required: fault=1 and fault_code=1 at 500 cycles after FIRE entry; detector_trigger stays 0; state IDLE.
- Bouncy wire with WIRE_DEBOUNCE_EN:
  - Stimulus: wire toggles every 3 cycles ×10, then held high.
  - Required: detector_trigger asserts only after 8 stable-high cycles plus the synchroniser delay.
  - Without the macro: triggers on the first edge.
- Ready handshake:
  - Stimulus: ready[1]=0 at confirmation, enable=4'b0011.
  - Required: trigger=4'b0001.
  - Stimulus: all enabled channels not ready.
  - Required: fault_code=2, no trigger pulse.
- Reset mid-pulse:
  - Stimulus: reset=0 for 1 cycle at the 2nd cycle of the detonator pulse.
  - Required: detonator_trigger=0 on the next cycle; busy=0; subsequent fg edges are ignored until a new start.
- Repeated start/fg:
  - Stimulus: start pulses during WAIT_FG and WAIT_RDY; fg edges during WAIT_FG.
  - Required: no re-arm and no second detonator pulse.

Source files
------------

// File: rtl/sync_sequencer.sv
// One-shot sequencer: start -> arm on fast-gate edge -> delay -> detonator pulse -> wire check -> detector pulses.
// Optional WIRE_DEBOUNCE_EN: wire confirmation needs DEBOUNCE_CYC consecutive high samples instead of a rising edge.
`timescale 1ns/1ps
module sync_sequencer #(
  parameter int N_DET        = 4,
  parameter int CNT_W        = 24,
  parameter int FG_DELAY     = 400000,
  parameter int PULSE_CYC    = 200,
  parameter int WIRE_TIMEOUT = 20000,
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_signal,
  input  logic             fg_signal,
  input  logic             wire_sensor,
  input  logic [N_DET-1:0] det_enable,
  input  logic [N_DET-1:0] detector_ready,
  output logic             detonator_trigger,
  output logic [N_DET-1:0] detector_trigger,
  output logic             busy,
  output logic             fault,
  output logic [1:0]       fault_code
);

  localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;

  if ((CNT_W < 2) || (CNT_W > 62) || (N_DET < 1) || (N_DET > 16) ||
      (FG_DELAY < 1) || (longint'(FG_DELAY) > CNT_MAX) ||
      (PULSE_CYC < 1) || (longint'(PULSE_CYC) > CNT_MAX) ||
      (WIRE_TIMEOUT < 1) || (longint'(WIRE_TIMEOUT) > CNT_MAX) ||
      (DEBOUNCE_CYC < 1) || (longint'(DEBOUNCE_CYC) > CNT_MAX)) begin : g_bad_params
    $error("sync_sequencer: parameter out of range for CNT_W");
  end

  localparam logic [CNT_W-1:0] FG_LAST    = CNT_W'(FG_DELAY - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] WT_LAST    = CNT_W'(WIRE_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, ARMED, WAIT_FG, FIRE, WAIT_WIRE, TRIG, WAIT_RDY
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] wcnt;
  logic [N_DET-1:0] mask;
  logic [N_DET-1:0] act;
  logic [2:0]       start_sr;
  logic [2:0]       fg_sr;
  logic             start_rise;
  logic             fg_rise;
  logic             wire_ok;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // Bits [1:0] are the synchroniser; bit 2 is the previous synchronised value for edge detection.
  always_ff @(posedge clock) begin
    if (!reset) begin
      start_sr <= '0;
      fg_sr    <= '0;
    end else begin
      start_sr <= {start_sr[1:0], start_signal};
      fg_sr    <= {fg_sr[1:0], fg_signal};
    end
  end

  assign start_rise = start_sr[1] & ~start_sr[2];
  assign fg_rise    = fg_sr[1] & ~fg_sr[2];

`ifdef WIRE_DEBOUNCE_EN
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYC - 1);
  logic [1:0]       wire_sr;
  logic [CNT_W-1:0] dcnt;

  // dcnt counts consecutive high samples already seen; any low sample restarts it.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wire_sr <= '0;
      dcnt    <= '0;
    end else begin
      wire_sr <= {wire_sr[0], wire_sensor};
      dcnt    <= wire_sr[1] ? sat_inc(dcnt) : '0;
    end
  end

  assign wire_ok = wire_sr[1] && (dcnt >= DB_LAST);
`else
  logic [2:0] wire_sr;

  always_ff @(posedge clock) begin
    if (!reset) wire_sr <= '0;
    else        wire_sr <= {wire_sr[1:0], wire_sensor};
  end

  assign wire_ok = wire_sr[1] & ~wire_sr[2];
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      state             <= IDLE;
      cnt               <= '0;
      wcnt              <= '0;
      mask              <= '0;
      act               <= '0;
      detonator_trigger <= 1'b0;
      detector_trigger  <= '0;
      busy              <= 1'b0;
      fault             <= 1'b0;
      fault_code        <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start_rise) begin
            fault      <= 1'b0;
            fault_code <= 2'd0;
            busy       <= 1'b1;
            state      <= ARMED;
          end
        end
        ARMED: begin
          if (fg_rise) begin
            mask  <= det_enable;
            cnt   <= '0;
            state <= WAIT_FG;
          end
        end
        WAIT_FG: begin
          if (cnt >= FG_LAST) begin
            cnt               <= '0;
            wcnt              <= '0;
            detonator_trigger <= 1'b1;
            state             <= FIRE;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end
        FIRE: begin
          // Wire timeout runs from the first FIRE cycle, in parallel with the pulse counter.
          wcnt <= sat_inc(wcnt);
          if (cnt >= PULSE_LAST) begin
            cnt               <= '0;
            detonator_trigger <= 1'b0;
            state             <= WAIT_WIRE;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end
        WAIT_WIRE: begin
          if (wire_ok) begin
            act <= mask & detector_ready;
            if ((mask & detector_ready) != '0) begin
              detector_trigger <= mask & detector_ready;
              cnt              <= '0;
              state            <= TRIG;
            end else begin
              fault      <= 1'b1;
              fault_code <= 2'd2;
              busy       <= 1'b0;
              state      <= IDLE;
            end
          end else if (wcnt >= WT_LAST) begin
            fault      <= 1'b1;
            fault_code <= 2'd1;
            busy       <= 1'b0;
            state      <= IDLE;
          end else begin
            wcnt <= sat_inc(wcnt);
          end
        end
        TRIG: begin
          if (cnt >= PULSE_LAST) begin
            detector_trigger <= '0;
            state            <= WAIT_RDY;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end
        WAIT_RDY: begin
          if ((detector_ready & act) == act) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sync_sequencer.sv
// Scoreboard bench for sync_sequencer: stimulus pushes expected output events, a monitor pops and compares them.
`timescale 1ns/1ps
module tb_sync_sequencer;

  localparam int FG_DELAY = 100;
  localparam int PULSE    = 4;
  localparam int WTO      = 500;
  localparam int DEB      = 8;
  localparam int FIRE_LAT = 3 + FG_DELAY;
`ifdef WIRE_DEBOUNCE_EN
  localparam int WC         = 2 + DEB;
  localparam int BOUNCE_LAT = 30 + 2 + DEB;
`else
  localparam int WC         = 3;
  localparam int BOUNCE_LAT = 3;
`endif

  localparam int EV_DET = 0, EV_TRG = 1, EV_FLT = 2, EV_FCLR = 3, EV_IDLE = 4;

  typedef struct packed {
    int kind;
    int val;
    int t;
    int width;
  } ev_t;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start_signal = 1'b0;
  logic       fg_signal = 1'b0;
  logic       wire_sensor = 1'b0;
  logic [3:0] det_enable = 4'h0;
  logic [3:0] detector_ready = 4'hF;
  logic       detonator_trigger;
  logic [3:0] detector_trigger;
  logic       busy;
  logic       fault;
  logic [1:0] fault_code;

  int  cyc = 0;
  int  total = 0;
  int  bad = 0;
  ev_t exp_q[$];

  sync_sequencer #(
    .N_DET(4), .CNT_W(24), .FG_DELAY(FG_DELAY), .PULSE_CYC(PULSE),
    .WIRE_TIMEOUT(WTO), .DEBOUNCE_CYC(DEB)
  ) dut (
    .clock(clock), .reset(reset), .start_signal(start_signal), .fg_signal(fg_signal),
    .wire_sensor(wire_sensor), .det_enable(det_enable), .detector_ready(detector_ready),
    .detonator_trigger(detonator_trigger), .detector_trigger(detector_trigger),
    .busy(busy), .fault(fault), .fault_code(fault_code)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic ev_t mk(input int k, input int v, input int t, input int w);
    ev_t e;
    e.kind = k; e.val = v; e.t = t; e.width = w;
    return e;
  endfunction

  function automatic string kname(input int k);
    case (k)
      EV_DET:  return "detonator_pulse";
      EV_TRG:  return "detector_pulse";
      EV_FLT:  return "fault_set";
      EV_FCLR: return "fault_clear";
      EV_IDLE: return "busy_fall";
      default: return "unknown";
    endcase
  endfunction

  function automatic void expect_ev(input int k, input int v, input int t, input int w);
    exp_q.push_back(mk(k, v, t, w));
  endfunction

  task automatic check_ev(input ev_t got);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_%s got val=%0d t=%0d width=%0d required no event",
               kname(got.kind), got.val, got.t, got.width);
    end else begin
      e = exp_q.pop_front();
      if (got != e) begin
        bad++;
        $display("FAIL %s got kind=%s val=%0d t=%0d width=%0d required kind=%s val=%0d t=%0d width=%0d",
                 kname(e.kind), kname(got.kind), got.val, got.t, got.width,
                 kname(e.kind), e.val, e.t, e.width);
      end
    end
  endtask

  // Monitor: pulses are reported when they end, flags on their transitions.
  logic       det_p = 1'b0, busy_p = 1'b0, fault_p = 1'b0;
  logic [3:0] trg_p = 4'h0, trg_v = 4'h0;
  int         det_t0 = 0, trg_t0 = 0;

  always @(negedge clock) begin
    if (detonator_trigger && !det_p) det_t0 = cyc;
    if (!detonator_trigger && det_p) check_ev(mk(EV_DET, 1, det_t0, cyc - det_t0));
    if (detector_trigger != 4'h0 && trg_p == 4'h0) begin
      trg_t0 = cyc;
      trg_v  = detector_trigger;
    end
    if (detector_trigger == 4'h0 && trg_p != 4'h0) check_ev(mk(EV_TRG, int'(trg_v), trg_t0, cyc - trg_t0));
    if (fault && !fault_p) check_ev(mk(EV_FLT, int'(fault_code), cyc, 0));
    if (!fault && fault_p) check_ev(mk(EV_FCLR, int'(fault_code), cyc, 0));
    if (!busy && busy_p) check_ev(mk(EV_IDLE, 0, cyc, 0));
    det_p   = detonator_trigger;
    trg_p   = detector_trigger;
    fault_p = fault;
    busy_p  = busy;
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clock);
  endtask

  task automatic pulse_start();
    start_signal = 1'b1;
    repeat (4) @(negedge clock);
    start_signal = 1'b0;
  endtask

  task automatic pulse_fg();
    fg_signal = 1'b1;
    repeat (4) @(negedge clock);
    fg_signal = 1'b0;
  endtask

  task automatic check_idle_outputs(input string name);
    total++;
    if ({detonator_trigger, detector_trigger, busy, fault, fault_code} !== 9'd0) begin
      bad++;
      $display("FAIL %s got det=%b trg=%b busy=%b fault=%b code=%0d required all 0",
               name, detonator_trigger, detector_trigger, busy, fault, fault_code);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, w, t, s;
    ev_t e;

    @(negedge clock);
    repeat (3) @(negedge clock);
    check_idle_outputs("reset_state");
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check_idle_outputs("post_reset_idle");

    // Nominal shot; ready withdrawn during the pulse so WAIT_RDY must hold
    pulse_start();
    repeat (10) @(negedge clock);
    det_enable = 4'b1011;
    k = cyc;
    expect_ev(EV_DET, 1, k + FIRE_LAT, PULSE);
    pulse_fg();
    w = k + FIRE_LAT + 50;
    t = w + WC;
    expect_ev(EV_TRG, 4'b1011, t, PULSE);
    wait_until(w);
    wire_sensor = 1'b1;
    wait_until(t + 1);
    detector_ready = 4'h0;
    wait_until(t + 20);
    expect_ev(EV_IDLE, 0, t + 21, 0);
    detector_ready = 4'hF;
    wait_until(t + 25);
    wire_sensor = 1'b0;
    repeat (10) @(negedge clock);

    // Wire timeout
    pulse_start();
    repeat (10) @(negedge clock);
    det_enable = 4'hF;
    k = cyc;
    expect_ev(EV_DET, 1, k + FIRE_LAT, PULSE);
    expect_ev(EV_FLT, 1, k + FIRE_LAT + WTO, 0);
    expect_ev(EV_IDLE, 0, k + FIRE_LAT + WTO, 0);
    pulse_fg();
    wait_until(k + FIRE_LAT + WTO + 20);

    // Bouncy wire; the start also clears the sticky fault
    s = cyc;
    expect_ev(EV_FCLR, 0, s + 3, 0);
    pulse_start();
    repeat (10) @(negedge clock);
    k = cyc;
    expect_ev(EV_DET, 1, k + FIRE_LAT, PULSE);
    pulse_fg();
    w = k + FIRE_LAT + 50;
    t = w + BOUNCE_LAT;
    expect_ev(EV_TRG, 4'hF, t, PULSE);
    expect_ev(EV_IDLE, 0, t + 5, 0);
    wait_until(w);
    for (int i = 0; i < 10; i++) begin
      wire_sensor = ~wire_sensor;
      repeat (3) @(negedge clock);
    end
    wire_sensor = 1'b1;
    wait_until(t + 10);
    wire_sensor = 1'b0;
    repeat (10) @(negedge clock);

    // Channel 1 enabled but not ready: only channel 0 fires
    det_enable = 4'b0011;
    detector_ready = 4'b1101;
    pulse_start();
    repeat (10) @(negedge clock);
    k = cyc;
    expect_ev(EV_DET, 1, k + FIRE_LAT, PULSE);
    pulse_fg();
    w = k + FIRE_LAT + 50;
    t = w + WC;
    expect_ev(EV_TRG, 4'b0001, t, PULSE);
    expect_ev(EV_IDLE, 0, t + 5, 0);
    wait_until(w);
    wire_sensor = 1'b1;
    wait_until(t + 10);
    wire_sensor = 1'b0;
    repeat (10) @(negedge clock);

    // No enabled channel ready: fault code 2, no trigger
    detector_ready = 4'b1100;
    pulse_start();
    repeat (10) @(negedge clock);
    k = cyc;
    expect_ev(EV_DET, 1, k + FIRE_LAT, PULSE);
    pulse_fg();
    w = k + FIRE_LAT + 50;
    t = w + WC;
    expect_ev(EV_FLT, 2, t, 0);
    expect_ev(EV_IDLE, 0, t, 0);
    wait_until(w);
    wire_sensor = 1'b1;
    wait_until(t + 5);
    wire_sensor = 1'b0;
    detector_ready = 4'hF;
    det_enable = 4'hF;
    repeat (10) @(negedge clock);

    // Reset on the second detonator cycle truncates the pulse; later fg edges must not arm
    s = cyc;
    expect_ev(EV_FCLR, 0, s + 3, 0);
    pulse_start();
    repeat (10) @(negedge clock);
    k = cyc;
    expect_ev(EV_DET, 1, k + FIRE_LAT, 2);
    expect_ev(EV_IDLE, 0, k + FIRE_LAT + 2, 0);
    pulse_fg();
    wait_until(k + FIRE_LAT + 1);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    check_idle_outputs("after_mid_pulse_reset");
    for (int i = 0; i < 3; i++) begin
      repeat (20) @(negedge clock);
      pulse_fg();
    end
    repeat (250) @(negedge clock);

    // Simultaneous start+fg in IDLE, then repeated start/fg in WAIT_FG and WAIT_RDY
    start_signal = 1'b1;
    fg_signal = 1'b1;
    repeat (4) @(negedge clock);
    start_signal = 1'b0;
    fg_signal = 1'b0;
    repeat (16) @(negedge clock);
    k = cyc;
    expect_ev(EV_DET, 1, k + FIRE_LAT, PULSE);
    pulse_fg();
    wait_until(k + 30);
    start_signal = 1'b1;
    fg_signal = 1'b1;
    repeat (4) @(negedge clock);
    start_signal = 1'b0;
    fg_signal = 1'b0;
    w = k + FIRE_LAT + 50;
    t = w + WC;
    expect_ev(EV_TRG, 4'hF, t, PULSE);
    wait_until(w);
    wire_sensor = 1'b1;
    wait_until(t + 1);
    detector_ready = 4'h0;
    wait_until(t + 8);
    start_signal = 1'b1;
    fg_signal = 1'b1;
    repeat (4) @(negedge clock);
    start_signal = 1'b0;
    fg_signal = 1'b0;
    wait_until(t + 30);
    expect_ev(EV_IDLE, 0, t + 31, 0);
    detector_ready = 4'hF;
    wait_until(t + 35);
    wire_sensor = 1'b0;
    repeat (300) @(negedge clock);

    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      bad++;
      $display("FAIL missing_%s got nothing required val=%0d t=%0d width=%0d",
               kname(e.kind), e.val, e.t, e.width);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
